// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port (instruction/data) arbiter in front of a single
// SDRAM controller port. One transaction outstanding at a time:
// IDLE (grant + latch) -> BUSY (hold request until controller ack) -> DONE (ack pulse).
// Optional build macro SDRAM_ARB_ROUND_ROBIN_EN: alternate grants under contention;
// without it port 1 (data) always wins over port 0 (instruction).
module sdram_arbiter #(
    parameter int AW = 25,
    parameter int DW = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req0,
    input  logic            i_we0,
    input  logic [AW-1:0]   i_addr0,
    input  logic [DW-1:0]   i_wdata0,
    input  logic [DW/8-1:0] i_wstrb0,
    output logic            o_ack0,
    output logic [DW-1:0]   o_rdata0,
    input  logic            i_req1,
    input  logic            i_we1,
    input  logic [AW-1:0]   i_addr1,
    input  logic [DW-1:0]   i_wdata1,
    input  logic [DW/8-1:0] i_wstrb1,
    output logic            o_ack1,
    output logic [DW-1:0]   o_rdata1,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_wdata,
    output logic [DW/8-1:0] o_mem_wstrb,
    input  logic            i_mem_ack,
    input  logic [DW-1:0]   i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   grant_sel;   // port chosen this cycle (0 or 1)
    logic   take;        // IDLE with a request: latch the chosen port
    logic   gnt_q;       // port owning the outstanding transaction
    logic   mem_done;    // controller completion seen while BUSY

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic last_q;        // port granted most recently
`endif

    assign mem_done = (state_q == BUSY) && i_mem_ack;

    // Arbitration choice among the currently raised requests
    always_comb begin
        grant_sel = 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        if (i_req0 && i_req1)
            grant_sel = ~last_q;
        else
            grant_sel = i_req1;
`else
        grant_sel = i_req1;
`endif
    end

    // Next-state logic; DONE returns to IDLE unconditionally so requests seen there are ignored
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    take    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (i_mem_ack)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Memory-side request registers: loaded on grant, held until controller ack
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_wstrb <= '0;
            gnt_q       <= 1'b0;
        end else if (take) begin
            o_mem_req   <= 1'b1;
            gnt_q       <= grant_sel;
            o_mem_we    <= grant_sel ? i_we1    : i_we0;
            o_mem_addr  <= grant_sel ? i_addr1  : i_addr0;
            o_mem_wdata <= grant_sel ? i_wdata1 : i_wdata0;
            o_mem_wstrb <= grant_sel ? i_wstrb1 : i_wstrb0;
        end else if (mem_done) begin
            o_mem_req   <= 1'b0;
        end
    end

    // Requester-side response: capture read data per port, ack lands in the DONE cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ack0   <= 1'b0;
            o_ack1   <= 1'b0;
            o_rdata0 <= '0;
            o_rdata1 <= '0;
        end else begin
            o_ack0 <= mem_done && !gnt_q;
            o_ack1 <= mem_done &&  gnt_q;
            if (mem_done && !gnt_q)
                o_rdata0 <= i_mem_rdata;
            if (mem_done && gnt_q)
                o_rdata1 <= i_mem_rdata;
        end
    end

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    // Round-robin pointer: remembers the last granted port
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            last_q <= 1'b0;
        else if (take)
            last_q <= grant_sel;
    end
`endif

endmodule
